// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: sin/cos rotation and magnitude/atan2 vectoring,
// one micro-rotation per clock with quadrant pre-rotation and optional gain fix-up.
module cordic_iter #(
    parameter int DW        = 16,
    parameter int ITER      = 16,
    parameter int GAIN_COMP = 1,
    localparam int XW       = DW + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_mode,
    input  logic signed [DW-1:0] in_x,
    input  logic signed [DW-1:0] in_y,
    input  logic        [DW-1:0] in_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [XW-1:0] out_x,
    output logic signed [XW-1:0] out_y,
    output logic        [DW-1:0] out_z,
    output logic                 busy
);

    localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
    localparam int PW = XW + 17;
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);
    localparam logic signed [16:0] KQ = 17'sh04DBA;
    localparam logic [DW-1:0] HALF = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_ROTATE, S_COMP, S_DONE} state_t;

    function automatic logic [31:0] atan32(input int i);
        case (i)
            0:  return 32'h20000000;  1:  return 32'h12E4051E;
            2:  return 32'h09FB385B;  3:  return 32'h051111D4;
            4:  return 32'h028B0D43;  5:  return 32'h0145D7E1;
            6:  return 32'h00A2F61E;  7:  return 32'h00517C55;
            8:  return 32'h0028BE53;  9:  return 32'h00145F2F;
            10: return 32'h000A2F98;  11: return 32'h000517CC;
            12: return 32'h00028BE6;  13: return 32'h000145F3;
            14: return 32'h0000A2FA;  15: return 32'h0000517D;
            16: return 32'h000028BE;  17: return 32'h0000145F;
            18: return 32'h00000A30;  19: return 32'h00000518;
            20: return 32'h0000028C;  21: return 32'h00000146;
            22: return 32'h000000A3;  23: return 32'h00000051;
            24: return 32'h00000029;  25: return 32'h00000014;
            26: return 32'h0000000A;  27: return 32'h00000005;
            28: return 32'h00000003;  29: return 32'h00000001;
            30: return 32'h00000001;  default: return 32'h00000000;
        endcase
    endfunction

    // Round-to-nearest when narrowing the 32-bit table to DW bits.
    function automatic logic [DW-1:0] atan_tab(input int i);
        return DW'(({1'b0, atan32(i)} + ((33'd1 << (32 - DW)) >> 1)) >> (32 - DW));
    endfunction

    logic [DW-1:0] atan_lut [2**CW];
    for (genvar g = 0; g < 2**CW; g++) begin : g_lut
        assign atan_lut[g] = atan_tab(g);
    end

    state_t               state_q, state_d;
    logic signed [XW-1:0] x_q, x_d, y_q, y_d;
    logic        [DW-1:0] z_q, z_d;
    logic        [CW-1:0] cnt_q, cnt_d;
    logic                 mode_q, mode_d;

    logic signed [XW-1:0] xe, ye, xs, ys;
    logic        [DW-1:0] a_i;
    logic                 flip, d_pos;

    assign xe    = XW'(in_x);
    assign ye    = XW'(in_y);
    assign flip  = in_mode ? in_x[DW-1] : (in_z[DW-1] ^ in_z[DW-2]);
    assign xs    = x_q >>> cnt_q;
    assign ys    = y_q >>> cnt_q;
    assign a_i   = atan_lut[cnt_q];
    assign d_pos = mode_q ? y_q[XW-1] : ~z_q[DW-1];

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mode_d  = in_mode;
                    cnt_d   = '0;
                    state_d = S_ROTATE;
                    if (flip) begin
                        x_d = -xe;
                        y_d = -ye;
                        z_d = in_z + HALF;
                    end else begin
                        x_d = xe;
                        y_d = ye;
                        z_d = in_z;
                    end
                end
            end
            S_ROTATE: begin
                if (d_pos) begin
                    x_d = x_q - ys;
                    y_d = y_q + xs;
                    z_d = z_q - a_i;
                end else begin
                    x_d = x_q + ys;
                    y_d = y_q - xs;
                    z_d = z_q + a_i;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = (GAIN_COMP != 0) ? S_COMP : S_DONE;
                end
            end
            S_COMP: begin
                // Full-width signed product, floor-shifted back to Q0.
                x_d     = XW'((PW'(x_q) * PW'(KQ)) >>> 15);
                y_d     = XW'((PW'(y_q) * PW'(KQ)) >>> 15);
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_x     = out_valid ? x_q : '0;
    assign out_y     = out_valid ? y_q : '0;
    assign out_z     = out_valid ? z_q : '0;

endmodule

// File: tb/tb_cordic_iter.sv
// Scoreboard bench for cordic_iter: default build (DW=ITER=16, gain-compensated)
// plus a DW=ITER=12 raw-gain build.
module tb_cordic_iter;

    localparam int DW  = 16;
    localparam int XW  = DW + 2;
    localparam int DWB = 12;
    localparam int XWB = DWB + 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic                 in_valid, in_ready, in_mode, out_valid, out_ready, busy;
    logic signed [DW-1:0] in_x, in_y;
    logic        [DW-1:0] in_z, out_z;
    logic signed [XW-1:0] out_x, out_y;

    logic                  b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_busy;
    logic signed [DWB-1:0] b_in_x, b_in_y;
    logic        [DWB-1:0] b_in_z, b_out_z;
    logic signed [XWB-1:0] b_out_x, b_out_y;

    cordic_iter #(.DW(DW), .ITER(16), .GAIN_COMP(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_x(in_x), .in_y(in_y), .in_z(in_z),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x(out_x), .out_y(out_y), .out_z(out_z), .busy(busy)
    );

    cordic_iter #(.DW(DWB), .ITER(12), .GAIN_COMP(0)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_mode(b_in_mode),
        .in_x(b_in_x), .in_y(b_in_y), .in_z(b_in_z),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_x(b_out_x), .out_y(b_out_y), .out_z(b_out_z), .busy(b_busy)
    );

    typedef struct {
        int x;
        int y;
        int z;
        int id;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int errors = 0;
    int checks = 0;

    function automatic exp_t mk(int x, int y, int z, int id);
        exp_t e;
        e.x = x; e.y = y; e.z = z; e.id = id;
        return e;
    endfunction

    task automatic chk_tol(string nm, int id, int act, int exp, int tol);
        checks++;
        if (act - exp > tol || exp - act > tol) begin
            errors++;
            $display("FAIL %s #%0d: got %0d, expected %0d +-%0d", nm, id, act, exp, tol);
        end
    endtask

    task automatic chk_ang(string nm, int id, int act, int exp, int w, int tol);
        logic [31:0] d;
        int sd;
        d  = 32'(act - exp) << (32 - w);
        sd = $signed(d) >>> (32 - w);
        checks++;
        if (sd > tol || sd < -tol) begin
            errors++;
            $display("FAIL %s #%0d: got 0x%0h, expected 0x%0h +-%0d", nm, id, act, exp, tol);
        end
    endtask

    task automatic chk_eq(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (qa.size() == 0) begin
                chk_eq("unexpected_out_a", 1, 0);
            end else begin
                exp_t e;
                e = qa.pop_front();
                chk_tol("out_x", e.id, int'(out_x), e.x, 4);
                chk_tol("out_y", e.id, int'(out_y), e.y, 4);
                chk_ang("out_z", e.id, int'(out_z), e.z, DW, 3);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                chk_eq("unexpected_out_b", 1, 0);
            end else begin
                exp_t e;
                e = qb.pop_front();
                chk_tol("b_out_x", e.id, int'(b_out_x), e.x, 4);
                chk_tol("b_out_y", e.id, int'(b_out_y), e.y, 4);
                chk_ang("b_out_z", e.id, int'(b_out_z), e.z, DWB, 3);
            end
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send_a(bit mode, int x, int y, int z, bit push, exp_t e);
        bit ok;
        ok       = 1'b0;
        in_mode  = mode;
        in_x     = 16'(x);
        in_y     = 16'(y);
        in_z     = 16'(z);
        in_valid = 1'b1;
        if (push) qa.push_back(e);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) chk_eq("accept_timeout_a", 0, 1);
    endtask

    task automatic send_b(bit mode, int x, int y, int z, exp_t e);
        bit ok;
        ok         = 1'b0;
        b_in_mode  = mode;
        b_in_x     = 12'(x);
        b_in_y     = 12'(y);
        b_in_z     = 12'(z);
        b_in_valid = 1'b1;
        qb.push_back(e);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (b_in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        b_in_valid = 1'b0;
        if (!ok) chk_eq("accept_timeout_b", 0, 1);
    endtask

    task automatic wait_valid(bit sel_b, output int lat);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            lat = k;
            if ((sel_b ? b_out_valid : out_valid) == 1'b1) break;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 300; k++) begin
            if (qa.size() == 0 && qb.size() == 0) break;
            @(posedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        logic signed [XW-1:0] sx, sy;
        logic [DW-1:0] sz;

        rst = 1'b1;
        in_valid = 1'b0; in_mode = 1'b0; in_x = '0; in_y = '0; in_z = '0; out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_mode = 1'b0; b_in_x = '0; b_in_y = '0; b_in_z = '0; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_in_ready", int'(in_ready), 1);
        chk_eq("rst_busy", int'(busy), 0);
        chk_eq("rst_out_valid", int'(out_valid), 0);
        chk_eq("rst_out_x", int'(out_x), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 45 deg rotation of 16384 plus accept-to-valid latency
        send_a(1'b0, 16384, 0, 'h2000, 1'b1, mk(11585, 11585, 0, 1));
        wait_valid(1'b0, lat);
        chk_eq("latency_gc1", lat, 17);

        send_a(1'b0, 10000, 0, 'hC000, 1'b1, mk(0, -10000, 0, 2));
        send_a(1'b0, 10000, 0, 'h8000, 1'b1, mk(-10000, 0, 0, 3));
        send_a(1'b0, 10000, 5000, 'h4000, 1'b1, mk(-5000, 10000, 0, 4));
        send_a(1'b1, -10000, 0, 0, 1'b1, mk(10000, 0, 'h8000, 5));
        send_a(1'b1, 0, 16384, 0, 1'b1, mk(16384, 0, 'h4000, 6));
        drain();

        // Backpressure: results held, second request held off until after handshake
        out_ready = 1'b0;
        send_a(1'b0, 16384, 0, 0, 1'b1, mk(16384, 0, 0, 7));
        wait_valid(1'b0, lat);
        @(negedge clk);
        sx = out_x; sy = out_y; sz = out_z;
        in_mode = 1'b0; in_x = 16'sd10000; in_y = '0; in_z = 16'hC000; in_valid = 1'b1;
        qa.push_back(mk(0, -10000, 0, 8));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk_eq("bp_out_valid", int'(out_valid), 1);
            chk_eq("bp_in_ready", int'(in_ready), 0);
            chk_eq("bp_hold_x", int'(out_x), int'(sx));
            chk_eq("bp_hold_y", int'(out_y), int'(sy));
            chk_eq("bp_hold_z", int'(out_z), int'(sz));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_eq("bp_not_yet_accepted", int'(busy), 0);
        @(posedge clk);
        #1;
        chk_eq("bp_accepted_next", int'(busy), 1);
        in_valid = 1'b0;
        drain();

        // Reset while cnt==7 discards the operation
        send_a(1'b1, 1000, 1000, 0, 1'b0, mk(0, 0, 0, 0));
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_eq("mid_rst_busy", int'(busy), 0);
        chk_eq("mid_rst_in_ready", int'(in_ready), 1);
        chk_eq("mid_rst_out_valid", int'(out_valid), 0);
        chk_eq("mid_rst_out_x", int'(out_x), 0);
        chk_eq("mid_rst_out_y", int'(out_y), 0);
        chk_eq("mid_rst_out_z", int'(out_z), 0);
        // atan2(4000,3000) = 53.13 deg -> 9672
        send_a(1'b1, 3000, 4000, 0, 1'b1, mk(5000, 0, 9672, 9));
        drain();

        // Raw-gain build, 12 iterations
        send_b(1'b0, 1000, 0, 0, mk(1646, 0, 0, 10));
        wait_valid(1'b1, lat);
        chk_eq("latency_gc0", lat, 12);
        drain();

        if (qa.size() != 0 || qb.size() != 0) chk_eq("outputs_missing", qa.size() + qb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
